uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
//
// PURPOSE
// Parametrised UART receiver: configurable data width, parity and stop bits,
// 2-flop input synchroniser, framing/parity error detection and an on-chip
// receive FIFO with first-word-fall-through read port. Sits between the
// external RX pin and the CPU I/O bus; the CPU drains words at its own pace.
//
// PARAMETERS
// CLKS_PER_BIT  120  I_clk cycles per serial bit (>= 4)
// DATA_BITS     8    data bits per frame, 5..9, LSB first
// PARITY        0    0 = none, 1 = odd, 2 = even
// STOP_BITS     1    1 or 2 stop bits
// FIFO_DEPTH    16   receive FIFO entries, power of 2, >= 2
//
// PORTS
// I_clk           in   1                   clock
// I_reset         in   1                   synchronous, active-high reset
// I_data_bit      in   1                   asynchronous serial RX line, idle high
// I_read          in   1                   pop head of FIFO (ignored when empty)
// I_clear_errors  in   1                   clears O_overrun
// O_data          out  DATA_BITS           FIFO head word, valid when O_data_valid
// O_data_valid    out  1                   FIFO not empty
// O_fifo_count    out  $clog2(FIFO_DEPTH)+1 words currently stored
// O_overrun       out  1                   sticky: good frame dropped, FIFO full
// O_frame_error   out  1                   1-cycle pulse: stop bit sampled low
// O_parity_error  out  1                   1-cycle pulse: parity mismatch
//
// BEHAVIOUR
// - Reset (I_reset, synchronous, active-high; clock I_clk): state IDLE, bit
//   counter 0, FIFO empty, all outputs 0; synchroniser flops preset to 1 so no
//   false start. Reset mid-frame aborts the frame; nothing is pushed.
// - rx_s = I_data_bit after 2 flops (2-cycle latency). All sampling uses rx_s.
// - Bit counter width $clog2(CLKS_PER_BIT)+1, cleared on every state change.
// - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE | WAIT_HIGH.
//   IDLE: rx_s==0 -> START.
//   START: at count==CLKS_PER_BIT/2-1 sample; 0 -> DATA, 1 -> IDLE (glitch,
//     no error). Subsequent samples fall at count==CLKS_PER_BIT-1 (mid-bit).
//   DATA: DATA_BITS samples, bit i into shift reg position i (LSB first).
//   PARITY (only if PARITY!=0): one sample; odd: data+parity ones count odd;
//     even: even. Mismatch latched, frame continues.
//   STOP: STOP_BITS samples; any 0 -> frame error.
//   On last stop sample: frame error -> O_frame_error pulse, no push, go
//     WAIT_HIGH; else parity error -> O_parity_error pulse, no push, IDLE;
//     else push word, IDLE. Frame error takes priority over parity error.
//   WAIT_HIGH: stay until rx_s==1, then IDLE (break is not a new start).
// - Error pulses assert the cycle after the last stop sample, exactly 1 cycle.
// - FIFO: push on good frame; word visible (O_data_valid=1, O_data) the cycle
//   after the last stop sample. I_read while valid pops; next head (or
//   valid=0) appears next cycle. Pointers wrap modulo FIFO_DEPTH.
//   Full + push, no pop: word dropped, O_overrun<=1, count stays FIFO_DEPTH.
//   Full + push + pop same cycle: both happen, count unchanged, no overrun.
//   Empty + push + I_read same cycle: push only (read ignored).
//   O_overrun held until I_clear_errors or reset; clear and new overrun in
//   same cycle -> O_overrun stays 1.
//
// TESTING (CLKS_PER_BIT=16 unless stated)
// 1. 8N1, send 0xA5 -> O_data_valid=1, O_data=0xA5, O_fifo_count=1; I_read 1
//    cycle -> O_data_valid=0, count=0.
// 2. PARITY=2, send 0x03 with parity bit 1 -> one O_parity_error pulse,
//    count stays 0; same with parity bit 0 -> 0x03 stored.
// 3. Hold line low 20 bit times (break) -> exactly one O_frame_error, no push;
//    line high then frame 0x5A -> 0x5A stored.
// 4. Low glitch of 4 cycles on idle line -> no push, no error pulses.
// 5. FIFO_DEPTH=4, send 0x01..0x05 unread -> count=4, O_overrun=1; reads return
//    0x01..0x04 in order; I_clear_errors -> O_overrun=0.
// 6. DATA_BITS=9, STOP_BITS=2, send 0x1C3; assert I_reset after 3 data bits of
//    a second frame -> FIFO empty, outputs 0; next frame 0x0F0 stored intact.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// CPU-side bus of the UART receiver: FIFO read port, error status and clear strobe.
// The master modport is the CPU; the slave modport is the receiver.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          I_read;
    logic                          I_clear_errors;
    logic [DATA_BITS-1:0]          O_data;
    logic                          O_data_valid;
    logic [$clog2(FIFO_DEPTH):0]   O_fifo_count;
    logic                          O_overrun;
    logic                          O_frame_error;
    logic                          O_parity_error;

    modport master (
        output I_read, I_clear_errors,
        input  O_data, O_data_valid, O_fifo_count, O_overrun, O_frame_error, O_parity_error
    );

    modport slave (
        input  I_read, I_clear_errors,
        output O_data, O_data_valid, O_fifo_count, O_overrun, O_frame_error, O_parity_error
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with 2-flop synchroniser, parity/framing checks and a
// first-word-fall-through receive FIFO drained by the CPU.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 120,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic           I_clk,
    input  logic           I_reset,
    input  logic           I_data_bit,
    uart_rx_fifo_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(FIFO_DEPTH);
    localparam logic          ODD_PAR   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [1:0]             r_sync;
    logic                   w_rx;
    logic [CW-1:0]          r_count;
    logic [3:0]             r_bitIdx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parErr;
    logic                   r_stopErr;
    logic                   r_frameErrPulse;
    logic                   r_parErrPulse;
    logic                   w_sample;
    logic                   w_push;
    logic                   w_frameErr;
    logic                   w_parErr;

    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wrPtr;
    logic [AW-1:0]          r_rdPtr;
    logic [NW-1:0]          r_fifoCount;
    logic                   r_overrun;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_write;

    assign w_rx = r_sync[1];

    always_ff @(posedge I_clk) begin
        if (I_reset) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    // Frame verdict is decided on the last stop sample; framing beats parity.
    always_comb begin
        w_nextState = r_state;
        w_sample    = 1'b0;
        w_push      = 1'b0;
        w_frameErr  = 1'b0;
        w_parErr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx) w_nextState = S_START;
            end
            S_START: begin
                if (r_count == HALF_LAST) begin
                    w_sample    = 1'b1;
                    w_nextState = w_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_count == BIT_LAST) begin
                    w_sample = 1'b1;
                    if (r_bitIdx == DATA_LAST)
                        w_nextState = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (r_count == BIT_LAST) begin
                    w_sample    = 1'b1;
                    w_nextState = S_STOP;
                end
            end
            S_STOP: begin
                if (r_count == BIT_LAST) begin
                    w_sample = 1'b1;
                    if (r_bitIdx == STOP_LAST) begin
                        if (r_stopErr || !w_rx) begin
                            w_frameErr  = 1'b1;
                            w_nextState = S_WAIT_HIGH;
                        end else if (r_parErr) begin
                            w_parErr    = 1'b1;
                            w_nextState = S_IDLE;
                        end else begin
                            w_push      = 1'b1;
                            w_nextState = S_IDLE;
                        end
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (w_rx) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Data arrives LSB first, so shifting in at the MSB leaves bit 0 in place.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_sync          <= 2'b11;
            r_count         <= '0;
            r_bitIdx        <= '0;
            r_shift         <= '0;
            r_parErr        <= 1'b0;
            r_stopErr       <= 1'b0;
            r_frameErrPulse <= 1'b0;
            r_parErrPulse   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], I_data_bit};
            if (w_nextState != r_state || w_sample) r_count <= '0;
            else                                    r_count <= r_count + CW'(1);
            if (w_nextState != r_state) r_bitIdx <= '0;
            else if (w_sample)          r_bitIdx <= r_bitIdx + 4'd1;
            if (r_state == S_IDLE) begin
                r_parErr  <= 1'b0;
                r_stopErr <= 1'b0;
            end
            if (w_sample && r_state == S_DATA)
                r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
            if (w_sample && r_state == S_PARITY)
                r_parErr <= ((^{r_shift, w_rx}) != ODD_PAR);
            if (w_sample && r_state == S_STOP && !w_rx)
                r_stopErr <= 1'b1;
            r_frameErrPulse <= w_frameErr;
            r_parErrPulse   <= w_parErr;
        end
    end

    assign w_empty = (r_fifoCount == '0);
    assign w_full  = (r_fifoCount == FULL_CNT);
    assign w_pop   = bus.I_read && !w_empty;
    assign w_write = w_push && (!w_full || w_pop);

    always_ff @(posedge I_clk) begin
        if (!I_reset && w_write) r_mem[r_wrPtr] <= r_shift;
    end

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_fifoCount <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_write) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)   r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_write, w_pop})
                2'b10:   r_fifoCount <= r_fifoCount + NW'(1);
                2'b01:   r_fifoCount <= r_fifoCount - NW'(1);
                default: r_fifoCount <= r_fifoCount;
            endcase
            if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
            else if (bus.I_clear_errors)    r_overrun <= 1'b0;
        end
    end

    assign bus.O_data         = w_empty ? '0 : r_mem[r_rdPtr];
    assign bus.O_data_valid   = !w_empty;
    assign bus.O_fifo_count   = r_fifoCount;
    assign bus.O_overrun      = r_overrun;
    assign bus.O_frame_error  = r_frameErrPulse;
    assign bus.O_parity_error = r_parErrPulse;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: four receiver configurations, each fed
// serial frames while a queue holds the words each FIFO should return.
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic [3:0] rst = 4'hF;
    logic [3:0] rxLine = 4'hF;
    logic [3:0] readReq = 4'h0;
    logic [3:0] clrReq = 4'h0;

    int testCount = 0;
    int failCount = 0;
    int sel = 0;
    int feCnt [4] = '{0, 0, 0, 0};
    int peCnt [4] = '{0, 0, 0, 0};
    logic [8:0] expQ [$];
    logic       expOverrun;

    logic       obsValid;
    logic [8:0] obsData;
    logic [4:0] obsCount;
    logic       obsOverrun;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) ifA ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) ifB ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  ifC ();
    uart_rx_fifo_if #(.DATA_BITS(9), .FIFO_DEPTH(16)) ifD ();

    assign ifA.I_read = readReq[0];  assign ifA.I_clear_errors = clrReq[0];
    assign ifB.I_read = readReq[1];  assign ifB.I_clear_errors = clrReq[1];
    assign ifC.I_read = readReq[2];  assign ifC.I_clear_errors = clrReq[2];
    assign ifD.I_read = readReq[3];  assign ifD.I_clear_errors = clrReq[3];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
        dutA (.I_clk(clk), .I_reset(rst[0]), .I_data_bit(rxLine[0]), .bus(ifA));
    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
        dutB (.I_clk(clk), .I_reset(rst[1]), .I_data_bit(rxLine[1]), .bus(ifB));
    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
        dutC (.I_clk(clk), .I_reset(rst[2]), .I_data_bit(rxLine[2]), .bus(ifC));
    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16))
        dutD (.I_clk(clk), .I_reset(rst[3]), .I_data_bit(rxLine[3]), .bus(ifD));

    always_comb begin
        obsValid   = 1'b0;
        obsData    = '0;
        obsCount   = '0;
        obsOverrun = 1'b0;
        case (sel)
            0: begin obsValid = ifA.O_data_valid; obsData = {1'b0, ifA.O_data};
                     obsCount = ifA.O_fifo_count; obsOverrun = ifA.O_overrun; end
            1: begin obsValid = ifB.O_data_valid; obsData = {1'b0, ifB.O_data};
                     obsCount = ifB.O_fifo_count; obsOverrun = ifB.O_overrun; end
            2: begin obsValid = ifC.O_data_valid; obsData = {1'b0, ifC.O_data};
                     obsCount = {2'b00, ifC.O_fifo_count}; obsOverrun = ifC.O_overrun; end
            3: begin obsValid = ifD.O_data_valid; obsData = ifD.O_data;
                     obsCount = ifD.O_fifo_count; obsOverrun = ifD.O_overrun; end
            default: ;
        endcase
    end

    // Counting high cycles makes a stretched pulse show up as an extra count.
    always @(negedge clk) begin
        if (ifA.O_frame_error)  feCnt[0] <= feCnt[0] + 1;
        if (ifB.O_frame_error)  feCnt[1] <= feCnt[1] + 1;
        if (ifC.O_frame_error)  feCnt[2] <= feCnt[2] + 1;
        if (ifD.O_frame_error)  feCnt[3] <= feCnt[3] + 1;
        if (ifA.O_parity_error) peCnt[0] <= peCnt[0] + 1;
        if (ifB.O_parity_error) peCnt[1] <= peCnt[1] + 1;
        if (ifC.O_parity_error) peCnt[2] <= peCnt[2] + 1;
        if (ifD.O_parity_error) peCnt[3] <= peCnt[3] + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string tag, input int expValid, input int expCount,
                              input int expOver);
        checkOutput({tag, " valid"}, 32'(obsValid), 32'(expValid));
        checkOutput({tag, " count"}, 32'(obsCount), 32'(expCount));
        checkOutput({tag, " overrun"}, 32'(obsOverrun), 32'(expOver));
    endtask

    task automatic driveBit(input int dut, input logic v, input int cycles);
        rxLine[dut] = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyStimulus(input int dut, input logic [8:0] data, input int nData,
                                 input int parBit, input int nStop, input logic stopVal);
        driveBit(dut, 1'b0, CPB);
        for (int i = 0; i < nData; i++) driveBit(dut, data[i], CPB);
        if (parBit >= 0) driveBit(dut, parBit[0], CPB);
        for (int i = 0; i < nStop; i++) driveBit(dut, stopVal, CPB);
        rxLine[dut] = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic expectGood(input logic [8:0] data, input int depth);
        if (expQ.size() < depth) expQ.push_back(data);
        else                     expOverrun = 1'b1;
    endtask

    task automatic readWord(input string tag);
        logic [8:0] exp;
        if (expQ.size() == 0) begin
            checkOutput({tag, " scoreboard empty"}, 32'(obsValid), 32'd0);
        end else begin
            exp = expQ.pop_front();
            checkOutput({tag, " valid"}, 32'(obsValid), 32'd1);
            checkOutput({tag, " data"}, 32'(obsData), 32'(exp));
        end
        readReq[sel] = 1'b1;
        @(negedge clk);
        readReq[sel] = 1'b0;
    endtask

    initial begin
        int feBase;
        int peBase;
        expOverrun = 1'b0;
        repeat (3) @(negedge clk);
        rst = 4'h0;
        repeat (2) @(negedge clk);

        sel = 0;
        checkState("reset A", 0, 0, 0);
        checkOutput("reset A data", 32'(obsData), 32'd0);

        // 8N1 single word then drain
        feBase = feCnt[0];
        peBase = peCnt[0];
        applyStimulus(0, 9'h0A5, 8, -1, 1, 1'b1);
        expectGood(9'h0A5, 16);
        checkState("8N1 A5", 1, 1, 0);
        readWord("8N1 A5 read");
        checkState("8N1 after read", 0, 0, 0);
        checkOutput("8N1 no frame err", 32'(feCnt[0] - feBase), 32'd0);
        checkOutput("8N1 no parity err", 32'(peCnt[0] - peBase), 32'd0);

        // Break: 20 bit times low
        feBase = feCnt[0];
        driveBit(0, 1'b0, 20 * CPB);
        driveBit(0, 1'b1, 2 * CPB);
        checkOutput("break frame err", 32'(feCnt[0] - feBase), 32'd1);
        checkState("break no push", 0, 0, 0);
        applyStimulus(0, 9'h05A, 8, -1, 1, 1'b1);
        expectGood(9'h05A, 16);
        checkState("after break 5A", 1, 1, 0);
        readWord("after break read");

        // Short low glitch on idle line
        feBase = feCnt[0];
        peBase = peCnt[0];
        driveBit(0, 1'b0, 4);
        driveBit(0, 1'b1, 3 * CPB);
        checkState("glitch", 0, 0, 0);
        checkOutput("glitch frame err", 32'(feCnt[0] - feBase), 32'd0);
        checkOutput("glitch parity err", 32'(peCnt[0] - peBase), 32'd0);

        // Even parity: 0x03 has two ones, parity bit 1 is wrong, 0 is right
        sel = 1;
        peBase = peCnt[1];
        applyStimulus(1, 9'h003, 8, 1, 1, 1'b1);
        checkOutput("parity err pulse", 32'(peCnt[1] - peBase), 32'd1);
        checkState("parity err no push", 0, 0, 0);
        peBase = peCnt[1];
        applyStimulus(1, 9'h003, 8, 0, 1, 1'b1);
        expectGood(9'h003, 16);
        checkOutput("parity ok no pulse", 32'(peCnt[1] - peBase), 32'd0);
        checkState("parity ok", 1, 1, 0);
        readWord("parity ok read");

        // Depth-4 FIFO overflow
        sel = 2;
        expOverrun = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(2, 9'(k), 8, -1, 1, 1'b1);
            expectGood(9'(k), 4);
        end
        checkState("overflow", 1, 4, int'(expOverrun));
        for (int k = 0; k < 4; k++) readWord("overflow read");
        checkState("overflow drained", 0, 0, 1);
        clrReq[2] = 1'b1;
        @(negedge clk);
        clrReq[2] = 1'b0;
        checkOutput("overrun cleared", 32'(obsOverrun), 32'd0);

        // 9 data bits, 2 stop bits, reset mid-frame
        sel = 3;
        applyStimulus(3, 9'h1C3, 9, -1, 2, 1'b1);
        expectGood(9'h1C3, 16);
        checkState("9b2s 1C3", 1, 1, 0);
        checkOutput("9b2s 1C3 data", 32'(obsData), 32'h1C3);
        driveBit(3, 1'b0, CPB);
        driveBit(3, 1'b1, CPB);
        driveBit(3, 1'b0, CPB);
        driveBit(3, 1'b1, CPB);
        rxLine[3] = 1'b1;
        rst[3] = 1'b1;
        repeat (2) @(negedge clk);
        rst[3] = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkState("mid-frame reset", 0, 0, 0);
        checkOutput("mid-frame reset data", 32'(obsData), 32'd0);
        driveBit(3, 1'b1, 2 * CPB);
        checkState("aborted frame not pushed", 0, 0, 0);
        applyStimulus(3, 9'h0F0, 9, -1, 2, 1'b1);
        expectGood(9'h0F0, 16);
        checkState("9b2s 0F0", 1, 1, 0);
        readWord("9b2s 0F0 read");
        checkState("9b2s drained", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
